// File: rtl/data_break_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : data_break_sequencer
// Purpose  : Multi-channel data-break (DMA) arbiter and break-cycle sequencer
//            for the PDP-8/E core. Optional macro DB_ROUND_ROBIN_EN selects
//            rotating priority instead of fixed lowest-index priority.
// Revision : 1.0  initial release
// ============================================================================
module data_break_sequencer #(
    parameter int NCH          = 4,
    parameter int BREAK_CYCLES = 3,
    parameter int ADDR_W       = 15,
    parameter int MAX_BURST    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_boundary,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        req_write,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*12-1:0]     req_wdata,
    input  logic [11:0]           mem_rdata,
    output logic [NCH-1:0]        grant,
    output logic                  break_in_prog,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [11:0]           mem_wdata,
    output logic                  mem_we,
    output logic [11:0]           rdata_out,
    output logic [NCH-1:0]        done,
    output logic [2:0]            burst_cnt
);

    localparam int c_CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_YW = $clog2(BREAK_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BRK  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CW-1:0]     r_ch;
    logic [c_YW-1:0]     r_cyc;
    logic [2:0]          r_burst;
    logic [ADDR_W-1:0]   r_addr;
    logic [11:0]         r_wdata;
    logic                r_write;
    logic [11:0]         r_rdata;
    logic [NCH-1:0]      r_done;

    logic                w_last;
    logic [NCH-1:0]      w_mask;
    logic [NCH-1:0]      w_elig;
    logic                w_found;
    logic [c_CW-1:0]     w_sel;
    logic                w_start;
    logic [c_CW-1:0]     w_search_base;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_grant
            assign grant[gi] = (r_state == S_BRK) && (r_ch == c_CW'(gi));
        end
    endgenerate

    assign break_in_prog = (r_state == S_BRK);
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_we        = (r_state == S_BRK) && (r_cyc == c_YW'(1)) && r_write;
    assign rdata_out     = r_rdata;
    assign done          = r_done;
    assign burst_cnt     = r_burst;

    assign w_last = (r_state == S_BRK) && (r_cyc == c_YW'(BREAK_CYCLES - 1));
    // The finishing channel is masked at the chain decision; its done fires next clock.
    assign w_mask = r_done | (w_last ? grant : '0);
    assign w_elig = req & ~w_mask;

`ifdef DB_ROUND_ROBIN_EN
    logic [c_CW-1:0] r_ptr;

    assign w_search_base = r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_start) begin
            r_ptr <= (w_sel == c_CW'(NCH - 1)) ? '0 : w_sel + 1'b1;
        end
    end
`else
    assign w_search_base = '0;
`endif

    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(w_search_base) + i;
            if (j >= NCH) j = j - NCH;
            if (!w_found && w_elig[j]) begin
                w_found = 1'b1;
                w_sel   = c_CW'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_boundary && w_found) begin
                    w_state_nxt = S_BRK;
                    w_start     = 1'b1;
                end
            end
            S_BRK: begin
                if (w_last) begin
                    if (w_found && (r_burst < 3'(MAX_BURST))) begin
                        w_start = 1'b1;
                    end else if (w_found) begin
                        w_state_nxt = S_REL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_REL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_cyc   <= '0;
            r_burst <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= '0;
            if (w_start) begin
                r_ch    <= w_sel;
                r_addr  <= req_addr[w_sel*ADDR_W +: ADDR_W];
                r_wdata <= req_wdata[w_sel*12 +: 12];
                r_write <= req_write[w_sel];
                r_cyc   <= '0;
                r_burst <= (r_state == S_IDLE) ? 3'd1 : r_burst + 3'd1;
            end else if (r_state == S_BRK) begin
                r_cyc <= r_cyc + 1'b1;
            end
            if (w_last) begin
                r_done <= grant;
                if (!r_write) r_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_break_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_break_sequencer
// Purpose  : Directed self-checking bench for data_break_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_break_sequencer;

    localparam int NCH    = 4;
    localparam int ADDR_W = 15;

    logic                  clk;
    logic                  reset;
    logic                  cpu_boundary;
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        req_write;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH*12-1:0]     req_wdata;
    logic [11:0]           mem_rdata;
    logic [NCH-1:0]        grant;
    logic                  break_in_prog;
    logic [ADDR_W-1:0]     mem_addr;
    logic [11:0]           mem_wdata;
    logic                  mem_we;
    logic [11:0]           rdata_out;
    logic [NCH-1:0]        done;
    logic [2:0]            burst_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic auto_drop = 1'b0;

    data_break_sequencer #(
        .NCH(NCH), .BREAK_CYCLES(3), .ADDR_W(ADDR_W), .MAX_BURST(4)
    ) u_dut (
        .clk(clk), .reset(reset), .cpu_boundary(cpu_boundary),
        .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_rdata(mem_rdata), .grant(grant),
        .break_in_prog(break_in_prog), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .rdata_out(rdata_out),
        .done(done), .burst_cnt(burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~done;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        int         ch;
        int         we_cnt;

        reset = 1'b1; cpu_boundary = 1'b0; req = '0; req_write = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;

        // Reset wins over a simultaneous request and boundary
        req = 4'b0100; cpu_boundary = 1'b1;
        tick(); tick();
        check("rst_bip",   32'(break_in_prog), 32'd0);
        check("rst_grant", 32'(grant),         32'd0);
        check("rst_we",    32'(mem_we),        32'd0);
        check("rst_done",  32'(done),          32'd0);
        check("rst_burst", 32'(burst_cnt),     32'd0);
        check("rst_rdata", 32'(rdata_out),     32'd0);
        check("rst_addr",  32'(mem_addr),      32'd0);
        check("rst_wdata", 32'(mem_wdata),     32'd0);
        cpu_boundary = 1'b0; reset = 1'b0;

        // Single read on channel 2
        req = 4'b0100; req_write = '0;
        req_addr[2*ADDR_W +: ADDR_W] = 15'o01234;
        mem_rdata = 12'o5555;
        tick(); tick();
        check("rd_noboundary_bip", 32'(break_in_prog), 32'd0);
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        check("rd_c0_bip",   32'(break_in_prog), 32'd1);
        check("rd_c0_grant", 32'(grant),         32'b0100);
        check("rd_c0_addr",  32'(mem_addr),      32'o01234);
        check("rd_c0_burst", 32'(burst_cnt),     32'd1);
        check("rd_c0_we",    32'(mem_we),        32'd0);
        tick();
        check("rd_c1_we",    32'(mem_we),        32'd0);
        tick();
        check("rd_c2_bip",   32'(break_in_prog), 32'd1);
        check("rd_c2_done",  32'(done),          32'd0);
        tick();
        check("rd_end_done",  32'(done),          32'b0100);
        check("rd_end_bip",   32'(break_in_prog), 32'd0);
        check("rd_end_grant", 32'(grant),         32'd0);
        check("rd_end_rdata", 32'(rdata_out),     32'o5555);
        req = '0;
        tick();
        check("rd_done_clr", 32'(done), 32'd0);

        // Single write on channel 0; read data must not be captured
        do_reset();
        req = 4'b0001; req_write = 4'b0001;
        req_addr[0 +: ADDR_W] = 15'o70000;
        req_wdata[0 +: 12]    = 12'o7070;
        mem_rdata = 12'o1111;
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        we_cnt = 0;
        check("wr_addr",  32'(mem_addr),  32'o70000);
        check("wr_wdata", 32'(mem_wdata), 32'o7070);
        check("wr_c0_we", 32'(mem_we),    32'd0);
        we_cnt += int'(mem_we);
        tick();
        check("wr_c1_we", 32'(mem_we),    32'd1);
        we_cnt += int'(mem_we);
        tick();
        check("wr_c2_we", 32'(mem_we),    32'd0);
        we_cnt += int'(mem_we);
        tick();
        we_cnt += int'(mem_we);
        check("wr_we_count", 32'(we_cnt),    32'd1);
        check("wr_done",     32'(done),      32'b0001);
        check("wr_rdata_hold", 32'(rdata_out), 32'd0);
        req = '0; req_write = '0;
        tick();

        // Contention 4'b1011, each requester drops after its done
        do_reset();
        auto_drop = 1'b1;
        req = 4'b1011;
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        for (int k = 0; k < 9; k++) begin
            ch = (k < 3) ? 0 : (k < 6) ? 1 : 3;
            e  = 4'b0001 << ch;
            check($sformatf("ct_bip_%0d", k),   32'(break_in_prog), 32'd1);
            check($sformatf("ct_grant_%0d", k), 32'(grant),         32'(e));
            check($sformatf("ct_burst_%0d", k), 32'(burst_cnt),     32'(k / 3 + 1));
            e = (k == 3) ? 4'b0001 : (k == 6) ? 4'b0010 : 4'b0000;
            check($sformatf("ct_done_%0d", k),  32'(done),          32'(e));
            tick();
        end
        check("ct_end_bip",  32'(break_in_prog), 32'd0);
        check("ct_end_done", 32'(done),          32'b1000);
        auto_drop = 1'b0;
        req = '0;
        tick();

        // Burst limit: all four requests held continuously
        do_reset();
        req = 4'b1111;
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        for (int k = 0; k < 12; k++) begin
`ifdef DB_ROUND_ROBIN_EN
            ch = k / 3;
`else
            ch = (k / 3) % 2;
`endif
            e = 4'b0001 << ch;
            check($sformatf("bl_bip_%0d", k),   32'(break_in_prog), 32'd1);
            check($sformatf("bl_grant_%0d", k), 32'(grant),         32'(e));
            check($sformatf("bl_burst_%0d", k), 32'(burst_cnt),     32'(k / 3 + 1));
            tick();
        end
`ifdef DB_ROUND_ROBIN_EN
        e = 4'b1000;
`else
        e = 4'b0010;
`endif
        check("bl_rel_bip",  32'(break_in_prog), 32'd0);
        check("bl_rel_done", 32'(done),          32'(e));
        tick();
        check("bl_idle_bip", 32'(break_in_prog), 32'd0);
        check("bl_idle_done", 32'(done),         32'd0);
        tick(); tick(); tick();
        check("bl_wait_bip", 32'(break_in_prog), 32'd0);
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        check("bl_restart_grant", 32'(grant),     32'b0001);
        check("bl_restart_burst", 32'(burst_cnt), 32'd1);

        // Reset at cyc 1 of a write break aborts it cleanly
        do_reset();
        req = 4'b0010; req_write = 4'b0010;
        req_addr[1*ADDR_W +: ADDR_W] = 15'o00017;
        req_wdata[1*12 +: 12]        = 12'o0042;
        cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        tick();
        check("ra_c1_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; req = '0; req_write = '0;
        check("ra_we",    32'(mem_we),        32'd0);
        check("ra_bip",   32'(break_in_prog), 32'd0);
        check("ra_grant", 32'(grant),         32'd0);
        check("ra_done",  32'(done),          32'd0);
        check("ra_addr",  32'(mem_addr),      32'd0);
        check("ra_wdata", 32'(mem_wdata),     32'd0);
        check("ra_burst", 32'(burst_cnt),     32'd0);
        tick();
        check("ra_done_next", 32'(done),          32'd0);
        check("ra_bip_next",  32'(break_in_prog), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_break_sequencer.md
Name: data_break_sequencer

Overview:
Multi-channel data-break (DMA) arbiter and cycle sequencer for the PDP-8/E core. It generalises the single-source DB0..DB2 break path to NCH requesting peripherals (RK8E, future devices) and adds burst chaining and a configurable break length. The CPU major-state machine raises cpu_boundary at F3/D3/E3 and stalls while break_in_prog is high. The sequencer then owns the memory address/data path for the break.

Parameters:
NCH, 4, number of break channels (1..8)
BREAK_CYCLES, 3, clocks per break cycle (DB0..DB(n-1)), min 2
ADDR_W, 15, memory address width (3-bit field + 12-bit address)
MAX_BURST, 4, max consecutive breaks before CPU is forcibly released for one cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_boundary  in  1  CPU at a major-state boundary, break may start
req  in  NCH  per-channel break request, level, held until done
req_write  in  NCH  1 = write memory (to memory), 0 = read memory
req_addr  in  NCH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NCH*12  per-channel write data
mem_rdata  in  12  memory read data, valid in last break cycle
grant  out  NCH  one-hot, active for the whole break
break_in_prog  out  1  CPU stall
mem_addr  out  ADDR_W  memory address during break
mem_wdata  out  12  memory write data
mem_we  out  1  memory write strobe
rdata_out  out  12  captured read data
done  out  NCH  one-clock completion pulse per channel
burst_cnt  out  3  breaks taken in current burst

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, priority pointer 0. Reset mid-break aborts it: no done pulse, mem_we low next clock.
- States: IDLE, BRK, REL.
- IDLE: if cpu_boundary & |eligible_req, latch winner ch. Grant and break_in_prog go high next clock. Latch req_addr[ch], req_wdata[ch] and req_write[ch]. Set cyc=0, burst_cnt=1. Go to BRK.
- eligible_req = req & ~done_mask. done_mask = channels pulsing done this clock, so a channel is never re-granted in the cycle its done fires.
- Arbitration is fixed priority: lowest index wins.
- BRK: cyc increments each clock. mem_addr and mem_wdata come from latched values for the whole break.
- mem_we is high only at cyc==1 and only when latched write=1.
- At cyc==BREAK_CYCLES-1:
  - rdata_out <= mem_rdata on reads; rdata_out holds its value on writes.
  - done[ch] pulses the next clock; grant clears.
  - If another eligible req exists and burst_cnt<MAX_BURST, start the next break directly with cyc=0 and burst_cnt+1. break_in_prog stays high.
  - Else if burst_cnt==MAX_BURST and a req is pending, go to REL.
  - Else go to IDLE with break_in_prog low.
- REL: break_in_prog low for exactly one clock, then IDLE. A new break then needs a fresh cpu_boundary.
- Latency: cpu_boundary & req at clock N gives break_in_prog=1 at N+1 and done at N+1+BREAK_CYCLES.
- cpu_boundary is sampled only in IDLE; it is ignored during BRK/REL.
- A req dropping mid-break does not abort the break.
- Simultaneous reset and req: reset wins.
- Chained breaks never need cpu_boundary.

Optional Feature:
DB_ROUND_ROBIN_EN
- Defined: rotating priority. Search starts at (last granted + 1) mod NCH; the pointer updates on each grant and resets to 0.
- Undefined: fixed priority, lowest index first; no pointer register.

Test Plan:
- Single read, BREAK_CYCLES=3: req[2]=1, req_write[2]=0, addr 15'o01234, cpu_boundary pulse at clock 10, mem_rdata=12'o5555 -> break_in_prog 11..13, grant=4'b0100, mem_we never high, done[2] at 14, rdata_out=12'o5555.
- Single write: req[0], req_write=1, wdata 12'o7070, addr 15'o70000 -> mem_we high exactly one clock (cyc 1), mem_addr=15'o70000, mem_wdata=12'o7070, done[0] after 3 breaks cycles.
- Contention with fixed priority: req=4'b1011 held with each requester dropping after its done -> grant order 0,1,3 chained, break_in_prog continuously high 9 clocks, burst_cnt 1,2,3.
- Burst limit, MAX_BURST=4: all 4 reqs held continuously -> 4 chained breaks, break_in_prog low exactly 1 clock (REL), no further break until next cpu_boundary.
- Reset at cyc==1 of a write break -> next clock all outputs 0, no done pulse, state IDLE.
- DB_ROUND_ROBIN_EN defined, req=4'b1111 held -> grant order 0,1,2,3 then 0 after release; undefined -> channel 0 re-granted after each done-mask clock.
